branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_pkg.sv | 26 ++
 rtl/branch_perf_cnt.sv | 25 ++
 rtl/branch_ctrl.sv | 104 ++++++++++
 tb/tb_branch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution controller: FSM encoding,
// datapath widths, the Decode->Execute register layout and the saturating
// increment used by the performance counters.
package branch_ctrl_pkg;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  typedef struct packed {
    logic            valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [PC_W-1:0] fallthru;
  } de_reg_t;

  // Add one unless already at all-ones, so counters stick at their maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/branch_perf_cnt.sv
// Saturating event counter with enable. Cleared by the asynchronous
// active-low reset, counts one per enabled cycle and holds at all-ones.
module branch_perf_cnt
  import branch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Counter register: clear on reset, saturating increment on each event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= sat_inc(count_q);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller. Carries the Decode-stage prediction into
// Execute, compares it against the real outcome, and on a mispredict
// flushes the front end and redirects Fetch in the same cycle. A one-cycle
// RECOVER state follows every mispredict, during which the predictor is
// ignored and no new resolution is accepted.
// Optional feature: define BRANCH_PERF_CNT_EN to build the saturating
// branch / mispredict performance counters; otherwise both read zero.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_D,
  input  logic             stall_D,
  input  logic             pred_taken_D,
  input  logic [PC_W-1:0]  pred_target_D,
  input  logic [PC_W-1:0]  pc_plus4_D,
  input  logic             taken_E,
  input  logic [PC_W-1:0]  target_E,
  output logic             pred_use_D,
  output logic             resolve_E,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_t  state;
  state_t  state_next;
  de_reg_t de_q;
  logic    mispredict;

  // State register: reset always lands in RUN, dropping any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a mispredict costs exactly one RECOVER cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mispredict) state_next = RECOVER;
      RECOVER: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Outputs: resolution, mispredict detection and zero-latency redirect.
  always_comb begin
    pred_use_D     = (state == RUN);
    resolve_E      = de_q.valid && (state == RUN);
    mispredict     = resolve_E &&
                     ((taken_E != de_q.pred_taken) ||
                      (taken_E && de_q.pred_taken && (target_E != de_q.pred_target)));
    flush          = mispredict;
    redirect_valid = mispredict;
    redirect_pc    = '0;
    if (mispredict) begin
      redirect_pc = taken_E ? target_E : de_q.fallthru;
    end
  end

  // Decode->Execute register: a flush outranks a stall, and both insert a
  // bubble. The prediction is only recorded as taken if Fetch acted on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= '0;
    end else if (flush) begin
      de_q.valid <= 1'b0;
    end else if (stall_D) begin
      de_q.valid <= 1'b0;
    end else begin
      de_q.valid       <= branch_D;
      de_q.pred_taken  <= pred_taken_D & pred_use_D;
      de_q.pred_target <= pred_target_D;
      de_q.fallthru    <= pc_plus4_D;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  branch_perf_cnt u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (resolve_E),
    .count (branch_cnt)
  );

  branch_perf_cnt u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mispredict),
    .count (mispredict_cnt)
  );
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl. Inputs change 1 ns after
// each rising edge; combinational outputs are checked 2 ns later.
// Counter expectations follow BRANCH_PERF_CNT_EN (zero when undefined).
module tb_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch_D;
  logic        stall_D;
  logic        pred_taken_D;
  logic [31:0] pred_target_D;
  logic [31:0] pc_plus4_D;
  logic        taken_E;
  logic [31:0] target_E;
  logic        pred_use_D;
  logic        resolve_E;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int vectors;
  int miscompares;

  branch_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_D       (branch_D),
    .stall_D        (stall_D),
    .pred_taken_D   (pred_taken_D),
    .pred_target_D  (pred_target_D),
    .pc_plus4_D     (pc_plus4_D),
    .taken_E        (taken_E),
    .target_E       (target_E),
    .pred_use_D     (pred_use_D),
    .resolve_E      (resolve_E),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value for n events, zero when counters are not built.
  function automatic logic [31:0] expCnt(input logic [31:0] n);
`ifdef BRANCH_PERF_CNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic applyStimulus(input logic br, input logic st, input logic pt,
                               input logic [31:0] ptgt, input logic [31:0] pc4,
                               input logic tk, input logic [31:0] tgt);
    branch_D      = br;
    stall_D       = st;
    pred_taken_D  = pt;
    pred_target_D = ptgt;
    pc_plus4_D    = pc4;
    taken_E       = tk;
    target_E      = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_flush", {31'b0, flush}, 32'h0);
    checkOutput("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_resolve", {31'b0, resolve_E}, 32'h0);
    checkOutput("rst_pred_use", {31'b0, pred_use_D}, 32'h1);
    checkOutput("rst_branch_cnt", branch_cnt, 32'h0);
    checkOutput("rst_mispredict_cnt", mispredict_cnt, 32'h0);
    #1 rst_n = 1'b1;

    // Five idle cycles with no branches.
    for (int i = 0; i < 5; i++) begin
      tick();
      settle();
      checkOutput("idle_flush", {31'b0, flush}, 32'h0);
      checkOutput("idle_redirect_valid", {31'b0, redirect_valid}, 32'h0);
      checkOutput("idle_pred_use", {31'b0, pred_use_D}, 32'h1);
    end
    checkOutput("idle_branch_cnt", branch_cnt, 32'h0);
    checkOutput("idle_mispredict_cnt", mispredict_cnt, 32'h0);

    // Correctly predicted taken branch to 0x100.
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h4, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    settle();
    checkOutput("hit_resolve", {31'b0, resolve_E}, 32'h1);
    checkOutput("hit_flush", {31'b0, flush}, 32'h0);
    checkOutput("hit_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    checkOutput("hit_redirect_pc", redirect_pc, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    settle();
    checkOutput("hit_pred_use", {31'b0, pred_use_D}, 32'h1);
    checkOutput("hit_branch_cnt", branch_cnt, expCnt(1));
    checkOutput("hit_mispredict_cnt", mispredict_cnt, expCnt(0));

    // Predicted not taken, actually taken to 0x200.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h44, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
    settle();
    checkOutput("nt_flush", {31'b0, flush}, 32'h1);
    checkOutput("nt_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    checkOutput("nt_redirect_pc", redirect_pc, 32'h200);
    checkOutput("nt_resolve", {31'b0, resolve_E}, 32'h1);
    tick();
    // RECOVER: a branch predicted taken here must be recorded as not taken.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h500, 32'h60, 1'b0, 32'h0);
    settle();
    checkOutput("rec_pred_use", {31'b0, pred_use_D}, 32'h0);
    checkOutput("rec_resolve", {31'b0, resolve_E}, 32'h0);
    checkOutput("rec_flush", {31'b0, flush}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    settle();
    checkOutput("post_rec_pred_use", {31'b0, pred_use_D}, 32'h1);
    checkOutput("masked_pred_resolve", {31'b0, resolve_E}, 32'h1);
    checkOutput("masked_pred_flush", {31'b0, flush}, 32'h0);
    tick();
    settle();
    checkOutput("nt_branch_cnt", branch_cnt, expCnt(3));
    checkOutput("nt_mispredict_cnt", mispredict_cnt, expCnt(1));

    // Predicted taken to 0x300, actually not taken: fall through to 0x48.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'h48, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    settle();
    checkOutput("tnt_flush", {31'b0, flush}, 32'h1);
    checkOutput("tnt_redirect_pc", redirect_pc, 32'h48);
    tick();
    tick();
    // Predicted taken to 0x300, actually taken to 0x304.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'h48, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h304);
    settle();
    checkOutput("tgt_flush", {31'b0, flush}, 32'h1);
    checkOutput("tgt_redirect_pc", redirect_pc, 32'h304);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    settle();
    checkOutput("tgt_branch_cnt", branch_cnt, expCnt(5));
    checkOutput("tgt_mispredict_cnt", mispredict_cnt, expCnt(3));

    // Mispredict while Decode is stalled with a branch in it.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h80, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h900, 32'h84, 1'b1, 32'h700);
    settle();
    checkOutput("stall_flush", {31'b0, flush}, 32'h1);
    checkOutput("stall_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    checkOutput("stall_redirect_pc", redirect_pc, 32'h700);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    settle();
    checkOutput("stall_rec_resolve", {31'b0, resolve_E}, 32'h0);
    checkOutput("stall_rec_pred_use", {31'b0, pred_use_D}, 32'h0);
    tick();
    settle();
    checkOutput("stall_post_resolve", {31'b0, resolve_E}, 32'h0);
    checkOutput("stall_branch_cnt", branch_cnt, expCnt(6));
    checkOutput("stall_mispredict_cnt", mispredict_cnt, expCnt(4));

    // Reset pulsed during RECOVER.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hA0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hB0);
    settle();
    checkOutput("prerst_flush", {31'b0, flush}, 32'h1);
    tick();
    settle();
    checkOutput("prerst_pred_use", {31'b0, pred_use_D}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("rstrec_pred_use", {31'b0, pred_use_D}, 32'h1);
    checkOutput("rstrec_branch_cnt", branch_cnt, 32'h0);
    checkOutput("rstrec_mispredict_cnt", mispredict_cnt, 32'h0);
    rst_n = 1'b1;
    tick();
    settle();
    checkOutput("rstrec_run_pred_use", {31'b0, pred_use_D}, 32'h1);
    checkOutput("rstrec_run_resolve", {31'b0, resolve_E}, 32'h0);

    // Reset asserted while a mispredict is being resolved.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'hC0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hD0);
    settle();
    checkOutput("midres_flush", {31'b0, flush}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midres_rst_flush", {31'b0, flush}, 32'h0);
    checkOutput("midres_rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    checkOutput("midres_rst_redirect_pc", redirect_pc, 32'h0);
    rst_n = 1'b1;
    tick();
    settle();
    checkOutput("midres_run_pred_use", {31'b0, pred_use_D}, 32'h1);

`ifdef BRANCH_PERF_CNT_EN
    force u_dut.u_branch_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.u_branch_cnt.count_q;
`endif
    // Three back-to-back correctly predicted not-taken branches.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    settle();
`ifdef BRANCH_PERF_CNT_EN
    checkOutput("sat_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
`else
    checkOutput("sat_branch_cnt", branch_cnt, 32'h0);
`endif
    checkOutput("sat_mispredict_cnt", mispredict_cnt, 32'h0);
    checkOutput("sat_flush", {31'b0, flush}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
